// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Full-adder cell operating on the current LSBs.
  logic             bit_s;
  logic             carry_d;
  logic [WIDTH-1:0] s_sh_d;

  assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    s_sh_d            = s_sh_q >> 1;
    s_sh_d[WIDTH-1]   = bit_s;
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift registers are
  // reset too, so no stale operand bits survive an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // The DONE edge also accepts a start so back-to-back adds run every WIDTH+1 cycles.
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= carry_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            sum_q   <= s_sh_d;
            cout_q  <= carry_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            // carry_q is the carry into the MSB on this final edge.
            ovf_q   <= carry_q ^ carry_d;
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: per-cycle compare against an arithmetic
// model (WIDTH=8) plus literal checks, and a WIDTH=1 instance checked exhaustively.
module tb_serial_full_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         s1_start;
  logic [0:0]   s1_a;
  logic [0:0]   s1_b;
  logic         s1_cin;
  logic         s1_busy;
  logic         s1_done;
  logic [0:0]   s1_sum;
  logic         s1_cout;
  logic         s1_ovf;

  int checks = 0;
  int errors = 0;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s1_start),
    .a     (s1_a),
    .b     (s1_b),
    .cin   (s1_cin),
    .busy  (s1_busy),
    .done  (s1_done),
    .sum   (s1_sum),
    .cout  (s1_cout)
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ,
    .ovf   (s1_ovf)
`endif
  );

`ifndef SERIAL_FULL_ADDER_OVF_EN
  assign ovf    = 1'b0;
  assign s1_ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is an arithmetic sum whose result appears
  // WIDTH edges after acceptance; m_left counts edges to go (-1 = idle, 0 = done cycle).
  int           m_left;
  logic [W-1:0] m_pend_sum, exp_sum;
  logic         m_pend_cout, exp_cout;
  logic         m_pend_ovf, exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = -1;
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
    end else if (m_left <= 0 && start) begin
      logic [W:0] full;
      longint     sr;
      full        = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      m_pend_sum  = full[W-1:0];
      m_pend_cout = full[W];
      sr          = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      m_pend_ovf  = (sr > 127) || (sr < -128);
      m_left      = W;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        exp_sum  = m_pend_sum;
        exp_cout = m_pend_cout;
        exp_ovf  = m_pend_ovf;
      end
    end else begin
      m_left = -1;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(busy), 64'(m_left >= 0));
    check("cyc_done", 64'(done), 64'(m_left == 0));
    check("cyc_sum",  64'(sum),  64'(exp_sum));
    check("cyc_cout", 64'(cout), 64'(exp_cout));
`ifdef SERIAL_FULL_ADDER_OVF_EN
    check("cyc_ovf",  64'(ovf),  64'(exp_ovf));
`endif
  end

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 50);
    if (g >= 50) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #2;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    check({nm, "_done_seen"}, 64'(seen), 64'(1));
    check({nm, "_latency"},   64'(n),    64'(9));
    check({nm, "_sum"},       64'(sum),  64'(es));
    check({nm, "_cout"},      64'(cout), 64'(ec));
`ifdef SERIAL_FULL_ADDER_OVF_EN
    check({nm, "_ovf"},       64'(ovf),  64'(eo));
`else
    if (eo !== 1'bx) check({nm, "_ovf_absent"}, 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    if (busy) busy_n++;
    check({nm, "_busy_cycles"}, 64'(busy_n), 64'(9));
  endtask

  task automatic run_op1(input logic ta, input logic tb, input logic tc);
    int n = 0;
    bit seen = 0;
    logic [1:0] tot;
    tot = 2'(ta) + 2'(tb) + 2'(tc);
    @(posedge clk); #2;
    s1_start = 1'b1; s1_a = ta; s1_b = tb; s1_cin = tc;
    @(posedge clk); #2;
    s1_start = 1'b0; s1_a = ~ta; s1_b = ~tb; s1_cin = ~tc;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (s1_done) seen = 1;
    end
    check("w1_done_seen", 64'(seen),    64'(1));
    check("w1_latency",   64'(n),       64'(2));
    check("w1_sum",       64'(s1_sum),  64'(tot[0]));
    check("w1_cout",      64'(s1_cout), 64'(tot[1]));
    @(negedge clk);
    check("w1_busy_after", 64'(s1_busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum",  64'(sum),  64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf",  64'(ovf),  64'(0));
    check("rst_w1_busy", 64'(s1_busy), 64'(0));
    #1 rst_n = 1'b1;

    // Hand-computed vectors pin the model as well as the DUT.
    run_op("add_3c_15", 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Start held high: one add every WIDTH+1 cycles.
    begin
      int last = -1;
      int cnt_d = 0;
      wait_idle();
      @(posedge clk); #2;
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (done) begin
          cnt_d++;
          check("hold_sum", 64'(sum), 64'h03);
          if (last >= 0) check("hold_period", 64'(i - last), 64'(9));
          last = i;
        end
      end
      start = 1'b0;
      check("hold_count", 64'(cnt_d), 64'(4));
    end

    // Reset in the middle of an operation.
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum",  64'(sum),  64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Randomized traffic against the model, including back-to-back and ignored starts.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();

    // WIDTH=1 instance, all operand combinations.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      run_op1(vv[2], vv[1], vv[0]);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
